snn_learn_sched: RTL and testbench
==================================

Name: snn_learn_sched

Overview:
- Learning sequencer and weight owner for the two-input, two-neuron reward-modulated SNN datapath.
- Accepts input samples by handshake, drives the datapath through load, evaluate, reward and update phases, and holds the four signed synaptic weights.
- Applies saturating reward-gated weight updates, counts epochs, and reports busy/done to the top level.
- Replaces the datapath's free-running combinational weight update with one deterministic update per sample.

Parameters:
- WW, 5: synaptic weight width, signed two's complement; range -16..+15.
- EPOCHS, 16: samples per training run; legal range 1..255.
- SETTLE, 2: cycles EVAL waits for datapath spikes to settle; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a training run; honoured only in IDLE.
- abort  in  1  forces return to IDLE next cycle; weights are kept.
- wr_en  in  1  weight preload strobe; honoured only in IDLE.
- wr_idx  in  2  preload index.
- wr_data  in  WW  preload value.
- sample_valid  in  1  input sample offered.
- sample_ready  out  1  scheduler accepts a sample.
- sample_a  in  8  neuron-A input pair {hi nibble, lo nibble}.
- sample_b  in  8  neuron-B input pair {hi nibble, lo nibble}.
- dp_load  out  1  one-cycle strobe; datapath latches dp_in_a/dp_in_b.
- dp_in_a  out  8  registered sample_a.
- dp_in_b  out  8  registered sample_b.
- dp_eval  out  1  high while datapath evaluates.
- pre_spike  in  2  [0]=A fired, [1]=B fired; sampled on last EVAL cycle.
- post_spike  in  2  [0]=N1 fired, [1]=N2 fired; sampled on last EVAL cycle.
- reward_valid  in  1  reward present.
- reward  in  2  01=+1, 11=-1, 00/10=none.
- weights  out  4*WW  packed; [WW-1:0]=w0 (A->N1), then w1 (A->N2), w2 (B->N1), w3 (B->N2).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.
- epoch  out  8  samples completed in the current run.

Behaviour:
- Reset values: state IDLE, weights all 0, epoch 0, all strobes 0, dp_in_a/b 0, sample_ready 0.
- IDLE:
  - wr_en writes wr_data to weights[wr_idx] on the next edge.
  - start clears epoch and moves to WAIT_S.
  - If start and wr_en coincide, the write is performed and start is also taken.
- WAIT_S:
  - sample_ready=1.
  - On sample_valid&sample_ready, register sample_a/b into dp_in_a/b and go to LOAD.
- LOAD: dp_load=1 for exactly one cycle, then EVAL.
- EVAL:
  - dp_eval=1 for SETTLE cycles, counted by an internal counter.
  - On the last cycle, latch pre_spike and post_spike into pre_q/post_q, then go to WAIT_R.
- WAIT_R: waits indefinitely for reward_valid; latches reward and goes to UPDATE.
- UPDATE: one cycle; each weight w(i->j) is updated in parallel.
  - reward=+1, pre_q[i]&post_q[j]: +1.
  - reward=+1, pre_q[i]&!post_q[j]: -1.
  - reward=-1, pre_q[i]&post_q[j]: -1.
  - Otherwise, including reward none or pre_q[i]=0: hold.
  - Saturate: +15 stays +15; -16 stays -16. No wrap.
  - epoch increments.
  - If the new epoch equals EPOCHS, go to IDLE with done=1 for one cycle; else return to WAIT_S.
- Latency: sample accept to dp_load is 1 cycle; dp_load to spike latch is SETTLE cycles; reward to weight visible on weights is 2 cycles (WAIT_R, then UPDATE edge).
- abort:
  - Has priority over every transition.
  - Leaves weights unchanged, including when asserted during UPDATE (that update is discarded).
  - Keeps epoch at its current value; no done pulse.
- rst mid-run restores all reset values, including weights.
- sample_valid outside WAIT_S and reward_valid outside WAIT_R are ignored; no buffering.
- epoch is 8-bit; EPOCHS is limited to 255, so no wrap.

Decomposition:
- Shared package snn_pkg holds:
  - state enum {IDLE, WAIT_S, LOAD, EVAL, WAIT_R, UPDATE};
  - reward codes REW_POS=2'b01, REW_NEG=2'b11;
  - WMAX=+15, WMIN=-16;
  - weight index constants W_AN1..W_BN2.
- One sub-module, snn_wsat_upd: combinational per-weight saturating ±1/hold unit, instantiated 4 times.

Test Plan:
- Reset, then wr_idx=2, wr_data=-3 in IDLE, then start with EPOCHS=1 -> weights[14:10]=-3 (5'b11101); busy=1 one cycle after start.
- Sample a=8'h21, b=8'h00; pre=2'b01, post=2'b01; reward=01 -> w0 +1, w1 -1, w2/w3 unchanged; done pulses once; epoch=1.
- w0 preloaded +15, pre=01, post=01, reward=+1 -> w0 stays +15. w1 preloaded -16, same stimulus -> w1 stays -16.
- reward=2'b10 with all spikes high -> no weight changes; epoch still increments.
- abort asserted in WAIT_R -> IDLE next cycle; weights unchanged; no done; a new start resets epoch to 0.
- EPOCHS=3, sample_valid held high, reward given 4 cycles late each time -> exactly 3 dp_load pulses, each followed by SETTLE=2 cycles of dp_eval; done after the third UPDATE; sample_ready=0 in IDLE afterwards.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared types and constants for the SNN learning sequencer.
//   state_t       sequencer states
//   REW_POS/NEG   reward codes (any other code means "no reward")
//   WMAX/WMIN     saturation limits of a 5-bit signed weight
//   W_AN1..W_BN2  weight slot indices (input->neuron)
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_S,
        LOAD,
        EVAL,
        WAIT_R,
        UPDATE
    } state_t;

    localparam logic [1:0] REW_POS = 2'b01;
    localparam logic [1:0] REW_NEG = 2'b11;

    localparam int WMAX = 15;
    localparam int WMIN = -16;

    // slot index = {pre input, post neuron}: bit1 selects A/B, bit0 selects N1/N2
    localparam int W_AN1 = 0;
    localparam int W_AN2 = 1;
    localparam int W_BN1 = 2;
    localparam int W_BN2 = 3;

endpackage

// File: rtl/snn_wsat_upd.sv
// snn_wsat_upd: combinational saturating +1 / -1 / hold step for one weight.
// Ports:
//   i_w     current weight (signed)
//   i_pre   presynaptic spike of this synapse's input
//   i_post  postsynaptic spike of this synapse's neuron
//   i_rew   latched reward code
//   o_w     next weight, clamped to the signed range of WW bits
module snn_wsat_upd
    import snn_pkg::*;
#(
    parameter int WW = 5
) (
    input  logic signed [WW-1:0] i_w,
    input  logic                 i_pre,
    input  logic                 i_post,
    input  logic [1:0]           i_rew,
    output logic signed [WW-1:0] o_w
);

    localparam logic signed [WW-1:0] L_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] L_MIN = {1'b1, {(WW-1){1'b0}}};
    localparam logic signed [WW-1:0] L_ONE = 1;

    logic w_inc;
    logic w_dec;

    always_comb begin
        w_inc = i_pre && (i_rew == REW_POS) && i_post;
        // positive reward punishes a pre spike that failed to cause a post spike
        w_dec = i_pre && (((i_rew == REW_POS) && !i_post) ||
                          ((i_rew == REW_NEG) && i_post));
        o_w = i_w;
        if (w_inc && (i_w != L_MAX)) begin
            o_w = i_w + L_ONE;
        end else if (w_dec && (i_w != L_MIN)) begin
            o_w = i_w - L_ONE;
        end
    end

endmodule

// File: rtl/snn_learn_sched.sv
// snn_learn_sched: learning sequencer and weight owner for the two-input,
// two-neuron reward-modulated SNN datapath.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, abort              run control (start only in IDLE; abort wins always)
//   wr_en/wr_idx/wr_data      weight preload, IDLE only
//   sample_valid/ready, sample_a/b   input sample handshake
//   dp_load, dp_in_a/b, dp_eval      datapath control
//   pre_spike, post_spike     datapath spikes, latched on last EVAL cycle
//   reward_valid, reward      reward input (01=+1, 11=-1)
//   weights                   packed {w3,w2,w1,w0}
//   busy, done, epoch         status
//
// state  | meaning
// IDLE   | waiting for start; preload writes allowed
// WAIT_S | sample_ready high, waiting for a sample
// LOAD   | one-cycle dp_load strobe
// EVAL   | dp_eval high for SETTLE cycles, spikes latched on the last one
// WAIT_R | waiting (unbounded) for reward_valid
// UPDATE | apply weight step, count epoch, loop or finish
module snn_learn_sched
    import snn_pkg::*;
#(
    parameter int WW     = 5,
    parameter int EPOCHS = 16,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            wr_en,
    input  logic [1:0]      wr_idx,
    input  logic [WW-1:0]   wr_data,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic [7:0]      sample_a,
    input  logic [7:0]      sample_b,
    output logic            dp_load,
    output logic [7:0]      dp_in_a,
    output logic [7:0]      dp_in_b,
    output logic            dp_eval,
    input  logic [1:0]      pre_spike,
    input  logic [1:0]      post_spike,
    input  logic            reward_valid,
    input  logic [1:0]      reward,
    output logic [4*WW-1:0] weights,
    output logic            busy,
    output logic            done,
    output logic [7:0]      epoch
);

    localparam logic [7:0] L_EPOCHS      = 8'(EPOCHS);
    localparam logic [3:0] L_SETTLE_LAST = 4'(SETTLE - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [WW-1:0] r_w [4];
    logic signed [WW-1:0] w_w_upd [4];
    logic [3:0]           r_settle;
    logic [1:0]           r_pre_q;
    logic [1:0]           r_post_q;
    logic [1:0]           r_rew;
    logic [7:0]           r_epoch;
    logic [7:0]           w_epoch_inc;
    logic [7:0]           r_in_a;
    logic [7:0]           r_in_b;
    logic                 r_done;
    logic                 w_run_done;

    assign w_epoch_inc = r_epoch + 8'd1;

    for (genvar g = 0; g < 4; g++) begin : g_upd
        // slot g: pre input = g[1], post neuron = g[0]
        snn_wsat_upd #(.WW(WW)) u_upd (
            .i_w    (r_w[g]),
            .i_pre  (r_pre_q[g / 2]),
            .i_post (r_post_q[g % 2]),
            .i_rew  (r_rew),
            .o_w    (w_w_upd[g])
        );
        assign weights[g*WW +: WW] = r_w[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        sample_ready = 1'b0;
        dp_load      = 1'b0;
        dp_eval      = 1'b0;
        w_run_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = WAIT_S;
            end
            WAIT_S: begin
                sample_ready = 1'b1;
                if (sample_valid) w_state_nxt = LOAD;
            end
            LOAD: begin
                dp_load     = 1'b1;
                w_state_nxt = EVAL;
            end
            EVAL: begin
                dp_eval = 1'b1;
                if (r_settle == 4'd0) w_state_nxt = WAIT_R;
            end
            WAIT_R: begin
                if (reward_valid) w_state_nxt = UPDATE;
            end
            UPDATE: begin
                if (w_epoch_inc == L_EPOCHS) begin
                    w_state_nxt = IDLE;
                    w_run_done  = 1'b1;
                end else begin
                    w_state_nxt = WAIT_S;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
            w_run_done  = 1'b0;
        end
    end

    // Datapath registers; every update is suppressed by abort so that an
    // aborted cycle leaves weights, epoch and latches untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) r_w[k] <= '0;
            r_settle <= '0;
            r_pre_q  <= '0;
            r_post_q <= '0;
            r_rew    <= '0;
            r_epoch  <= '0;
            r_in_a   <= '0;
            r_in_b   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_run_done;
            if (!abort) begin
                case (r_state)
                    IDLE: begin
                        if (wr_en) r_w[wr_idx] <= wr_data;
                        if (start) r_epoch <= '0;
                    end
                    WAIT_S: begin
                        if (sample_valid) begin
                            r_in_a <= sample_a;
                            r_in_b <= sample_b;
                        end
                    end
                    LOAD: begin
                        r_settle <= L_SETTLE_LAST;
                    end
                    EVAL: begin
                        if (r_settle == 4'd0) begin
                            r_pre_q  <= pre_spike;
                            r_post_q <= post_spike;
                        end else begin
                            r_settle <= r_settle - 4'd1;
                        end
                    end
                    WAIT_R: begin
                        if (reward_valid) r_rew <= reward;
                    end
                    UPDATE: begin
                        for (int k = 0; k < 4; k++) r_w[k] <= w_w_upd[k];
                        r_epoch <= w_epoch_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign epoch   = r_epoch;
    assign dp_in_a = r_in_a;
    assign dp_in_b = r_in_b;

endmodule

// File: tb/tb_snn_learn_sched.sv
module tb_snn_learn_sched;

    localparam int WW     = 5;
    localparam int EPOCHS = 3;
    localparam int SETTLE = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [4:0]  wr_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  sample_a;
    logic [7:0]  sample_b;
    logic        dp_load;
    logic [7:0]  dp_in_a;
    logic [7:0]  dp_in_b;
    logic        dp_eval;
    logic [1:0]  pre_spike;
    logic [1:0]  post_spike;
    logic        reward_valid;
    logic [1:0]  reward;
    logic [19:0] weights;
    logic        busy;
    logic        done;
    logic [7:0]  epoch;

    int n_vec;
    int n_err;

    // reference model state: plain integers, clamped arithmetic
    int mw [4];
    int m_epoch;

    snn_learn_sched #(.WW(WW), .EPOCHS(EPOCHS), .SETTLE(SETTLE)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_a     (sample_a),
        .sample_b     (sample_b),
        .dp_load      (dp_load),
        .dp_in_a      (dp_in_a),
        .dp_in_b      (dp_in_b),
        .dp_eval      (dp_eval),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .reward_valid (reward_valid),
        .reward       (reward),
        .weights      (weights),
        .busy         (busy),
        .done         (done),
        .epoch        (epoch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Weight (input i -> neuron j) uses pre[i], post[j]; slot = 2*i + j.
    function automatic void model_update(input logic [1:0] pre, input logic [1:0] post,
                                         input logic [1:0] rew);
        for (int i = 0; i < 4; i++) begin
            int d;
            int v;
            logic pi;
            logic pj;
            pi = pre[i / 2];
            pj = post[i % 2];
            d  = 0;
            if (rew == 2'b01 && pi)            d = pj ? 1 : -1;
            else if (rew == 2'b11 && pi && pj) d = -1;
            v = mw[i] + d;
            if (v > 15)  v = 15;
            if (v < -16) v = -16;
            mw[i] = v;
        end
        m_epoch = m_epoch + 1;
    endfunction

    function automatic logic [19:0] model_weights();
        logic [19:0] r;
        for (int i = 0; i < 4; i++) r[i*5 +: 5] = 5'(mw[i]);
        return r;
    endfunction

    function automatic int rnd_w();
        int c;
        c = int'($urandom_range(0, 3));
        if (c == 0) return 15;
        if (c == 1) return -16;
        return int'($urandom_range(0, 31)) - 16;
    endfunction

    task automatic preload(input int idx, input int val);
        wr_en   = 1'b1;
        wr_idx  = 2'(idx);
        wr_data = 5'(val);
        @(negedge clk);
        wr_en = 1'b0;
        mw[idx] = val;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_epoch = 0;
    endtask

    // Drives one sample through the protocol and reports what it saw.
    // amode 0: normal reward; 1: abort in WAIT_R; 2: abort during UPDATE.
    // Returns at the negedge after the UPDATE (or abort) edge.
    task automatic drive_sample(input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] pre, input logic [1:0] post,
                                input logic [1:0] rew, input int rdelay, input int amode,
                                output bit load_ok, output int eval_cycles, output bit to);
        int n;
        load_ok = 1'b0;
        eval_cycles = 0;
        to = 1'b0;
        sample_a = a;
        sample_b = b;
        sample_valid = 1'b1;
        n = 0;
        while (sample_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            to = 1'b1;
            sample_valid = 1'b0;
            return;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        sample_a = 8'($urandom);
        sample_b = 8'($urandom);
        load_ok = (dp_load === 1'b1) && (dp_in_a === a) && (dp_in_b === b);
        pre_spike = pre;
        post_spike = post;
        @(negedge clk);
        n = 0;
        while (dp_eval === 1'b1 && n < 50) begin
            eval_cycles++;
            @(negedge clk);
            n++;
        end
        pre_spike = 2'($urandom);
        post_spike = 2'($urandom);
        // junk sample offered in WAIT_R must be ignored
        sample_valid = (rdelay > 0);
        repeat (rdelay) @(negedge clk);
        sample_valid = 1'b0;
        if (amode == 1) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            return;
        end
        reward_valid = 1'b1;
        reward = rew;
        @(negedge clk);
        reward_valid = 1'b0;
        reward = 2'($urandom);
        if (amode == 2) abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mw[i] = 0;
        m_epoch = 0;
        n_vec++;
        if ({weights, epoch, busy, done, sample_ready, dp_load, dp_eval, dp_in_a, dp_in_b}
            !== {20'h0, 8'h0, 5'b0, 16'h0}) begin
            $display("FAIL reset_state: w=%h ep=%0d busy=%b done=%b rdy=%b ld=%b ev=%b a=%h b=%h expected all zero",
                     weights, epoch, busy, done, sample_ready, dp_load, dp_eval, dp_in_a, dp_in_b);
            n_err++;
        end
    endtask

    task automatic test_preload();
        preload(2, -3);
        n_vec++;
        if (weights[14:10] !== 5'b11101) begin
            $display("FAIL preload_w2: got %b expected 11101", weights[14:10]);
            n_err++;
        end
        // write and start in the same cycle: both take effect
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 5'd5; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        mw[0] = 5;
        m_epoch = 0;
        n_vec++;
        if ({busy, sample_ready, epoch} !== {1'b1, 1'b1, 8'd0}) begin
            $display("FAIL start_busy: busy=%b rdy=%b ep=%0d expected 1 1 0", busy, sample_ready, epoch);
            n_err++;
        end
        n_vec++;
        if (weights !== model_weights()) begin
            $display("FAIL preload_with_start: got %h expected %h", weights, model_weights());
            n_err++;
        end
    endtask

    task automatic test_learn_basic();
        bit ok;
        bit to;
        int ev;
        drive_sample(8'h21, 8'h00, 2'b01, 2'b01, 2'b01, 1, 0, ok, ev, to);
        model_update(2'b01, 2'b01, 2'b01);
        n_vec++;
        if (!ok || to || ev != SETTLE) begin
            $display("FAIL basic_protocol: load_ok=%b timeout=%b eval=%0d expected 1 0 %0d", ok, to, ev, SETTLE);
            n_err++;
        end
        n_vec++;
        if (weights !== {5'd0, 5'b11101, 5'b11111, 5'd6}) begin
            $display("FAIL basic_weights: got %h expected %h", weights, {5'd0, 5'b11101, 5'b11111, 5'd6});
            n_err++;
        end
        n_vec++;
        if ({epoch, done, busy} !== {8'd1, 1'b0, 1'b1}) begin
            $display("FAIL basic_epoch: ep=%0d done=%b busy=%b expected 1 0 1", epoch, done, busy);
            n_err++;
        end
        for (int s = 1; s < EPOCHS; s++) begin
            logic [1:0] p;
            logic [1:0] q;
            logic [1:0] r;
            p = 2'($urandom); q = 2'($urandom); r = 2'($urandom);
            drive_sample(8'($urandom), 8'($urandom), p, q, r, 0, 0, ok, ev, to);
            model_update(p, q, r);
        end
        n_vec++;
        if ({done, busy, epoch, weights} !== {1'b1, 1'b0, 8'(EPOCHS), model_weights()}) begin
            $display("FAIL basic_done: done=%b busy=%b ep=%0d w=%h expected 1 0 %0d %h",
                     done, busy, epoch, weights, EPOCHS, model_weights());
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            $display("FAIL basic_done_pulse: done=%b expected 0", done);
            n_err++;
        end
    endtask

    task automatic test_saturate();
        bit ok;
        bit to;
        int ev;
        preload(0, 15);
        preload(1, -16);
        preload(2, 15);
        preload(3, -16);
        start_run();
        // +1 reward: w0,w2 increment at +15, w1,w3 decrement at -16
        drive_sample(8'h11, 8'h22, 2'b11, 2'b01, 2'b01, 2, 0, ok, ev, to);
        model_update(2'b11, 2'b01, 2'b01);
        n_vec++;
        if (weights !== {5'b10000, 5'b01111, 5'b10000, 5'b01111}) begin
            $display("FAIL sat_hold: got %h expected %h", weights, {5'b10000, 5'b01111, 5'b10000, 5'b01111});
            n_err++;
        end
        // -1 reward, all spikes: everything steps down, -16 stays
        drive_sample(8'h33, 8'h44, 2'b11, 2'b11, 2'b11, 0, 0, ok, ev, to);
        model_update(2'b11, 2'b11, 2'b11);
        n_vec++;
        if (weights !== model_weights()) begin
            $display("FAIL sat_neg: got %h expected %h", weights, model_weights());
            n_err++;
        end
        // code 10 is "no reward"
        drive_sample(8'h55, 8'h66, 2'b11, 2'b11, 2'b10, 3, 0, ok, ev, to);
        model_update(2'b11, 2'b11, 2'b10);
        n_vec++;
        if ({weights, epoch, done} !== {model_weights(), 8'd3, 1'b1}) begin
            $display("FAIL rew_none: w=%h ep=%0d done=%b expected %h 3 1", weights, epoch, done, model_weights());
            n_err++;
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit to;
        int ev;
        start_run();
        n_vec++;
        if (epoch !== 8'd0) begin
            $display("FAIL start_clears_epoch: ep=%0d expected 0", epoch);
            n_err++;
        end
        drive_sample(8'h01, 8'h02, 2'b11, 2'b10, 2'b01, 0, 0, ok, ev, to);
        model_update(2'b11, 2'b10, 2'b01);
        drive_sample(8'h03, 8'h04, 2'b11, 2'b11, 2'b01, 2, 1, ok, ev, to);
        n_vec++;
        if ({busy, done, epoch, weights} !== {1'b0, 1'b0, 8'd1, model_weights()}) begin
            $display("FAIL abort_wait_r: busy=%b done=%b ep=%0d w=%h expected 0 0 1 %h",
                     busy, done, epoch, weights, model_weights());
            n_err++;
        end
        for (int i = 0; i < 4; i++) preload(i, 0);
        start_run();
        n_vec++;
        if (epoch !== 8'd0) begin
            $display("FAIL restart_epoch: ep=%0d expected 0", epoch);
            n_err++;
        end
        drive_sample(8'h05, 8'h06, 2'b11, 2'b11, 2'b01, 1, 2, ok, ev, to);
        n_vec++;
        if ({busy, done, epoch, weights} !== {1'b0, 1'b0, 8'd0, model_weights()}) begin
            $display("FAIL abort_update: busy=%b done=%b ep=%0d w=%h expected 0 0 0 %h",
                     busy, done, epoch, weights, model_weights());
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int loads;
        int evals;
        int dones;
        int bad_runs;
        int run;
        int wc;
        int cyc;
        bit armed;
        bit prev_eval;
        bit seen_done;
        loads = 0; evals = 0; dones = 0; bad_runs = 0; run = 0; wc = 0;
        armed = 0; prev_eval = 0; seen_done = 0; cyc = 0;
        for (int i = 0; i < 4; i++) preload(i, rnd_w());
        start_run();
        pre_spike = 2'b11;
        post_spike = 2'b10;
        sample_valid = 1'b1;
        sample_a = 8'h5A;
        sample_b = 8'hA5;
        while (!seen_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            reward_valid = 1'b0;
            if (dp_load === 1'b1) loads++;
            if (dp_eval === 1'b1) begin
                evals++;
                run++;
            end
            if (prev_eval && dp_eval !== 1'b1) begin
                if (run != SETTLE) bad_runs++;
                run = 0;
                armed = 1;
                wc = 0;
            end
            if (armed) begin
                if (wc == 4) begin
                    reward_valid = 1'b1;
                    reward = 2'b01;
                    armed = 0;
                    model_update(2'b11, 2'b10, 2'b01);
                end else begin
                    wc++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                seen_done = 1;
            end
            prev_eval = (dp_eval === 1'b1);
        end
        reward_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (!seen_done) begin
            $display("FAIL b2b_timeout: no done within 300 cycles");
            n_err++;
        end
        n_vec++;
        if (loads != 3 || evals != 3 * SETTLE || bad_runs != 0 || dones != 1) begin
            $display("FAIL b2b_counts: loads=%0d evals=%0d bad_runs=%0d dones=%0d expected 3 %0d 0 1",
                     loads, evals, bad_runs, dones, 3 * SETTLE);
            n_err++;
        end
        n_vec++;
        if ({sample_ready, busy, epoch, weights} !== {1'b0, 1'b0, 8'd3, model_weights()}) begin
            $display("FAIL b2b_end: rdy=%b busy=%b ep=%0d w=%h expected 0 0 3 %h",
                     sample_ready, busy, epoch, weights, model_weights());
            n_err++;
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        bit to;
        int ev;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) preload(i, rnd_w());
            start_run();
            for (int s = 0; s < EPOCHS; s++) begin
                logic [7:0] a;
                logic [7:0] b;
                logic [1:0] p;
                logic [1:0] q;
                logic [1:0] rw;
                a = 8'($urandom); b = 8'($urandom);
                p = 2'($urandom); q = 2'($urandom); rw = 2'($urandom);
                drive_sample(a, b, p, q, rw, int'($urandom_range(0, 5)), 0, ok, ev, to);
                model_update(p, q, rw);
                n_vec++;
                if (!ok || to || ev != SETTLE) begin
                    $display("FAIL rand_protocol r%0d s%0d: load_ok=%b timeout=%b eval=%0d", r, s, ok, to, ev);
                    n_err++;
                end
                n_vec++;
                if ({weights, epoch, done} !== {model_weights(), 8'(m_epoch), (s == EPOCHS - 1)}) begin
                    $display("FAIL rand_update r%0d s%0d: w=%h ep=%0d done=%b expected %h %0d %b",
                             r, s, weights, epoch, done, model_weights(), m_epoch, (s == EPOCHS - 1));
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        preload(0, 7);
        preload(3, -5);
        start_run();
        sample_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({weights, epoch, busy, dp_eval, dp_load, dp_in_a, dp_in_b} !== {20'h0, 8'h0, 3'b0, 16'h0}) begin
            $display("FAIL mid_reset: w=%h ep=%0d busy=%b ev=%b ld=%b a=%h b=%h expected all zero",
                     weights, epoch, busy, dp_eval, dp_load, dp_in_a, dp_in_b);
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_idx = 2'd0; wr_data = 5'd0;
        sample_valid = 1'b0; sample_a = 8'h00; sample_b = 8'h00;
        pre_spike = 2'b00; post_spike = 2'b00; reward_valid = 1'b0; reward = 2'b00;
        m_epoch = 0;
        for (int i = 0; i < 4; i++) mw[i] = 0;
        @(negedge clk);
        test_reset();
        test_preload();
        test_learn_basic();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
